// File: rtl/aes_inv_pkg.sv
// ============================================================================
// aes_inv_pkg: shared types and GF(2^8) helpers for the AES inverse cipher.
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_inv_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Returns 0 for an unsupported key size so the top level can reject it.
    function automatic int nr_of(input int key_bits);
        case (key_bits)
            128:     return 10;
            192:     return 12;
            256:     return 14;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] pmul_9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] pmul_b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] pmul_d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] pmul_e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {pmul_e(a0) ^ pmul_b(a1) ^ pmul_d(a2) ^ pmul_9(a3),
                pmul_9(a0) ^ pmul_e(a1) ^ pmul_b(a2) ^ pmul_d(a3),
                pmul_d(a0) ^ pmul_9(a1) ^ pmul_e(a2) ^ pmul_b(a3),
                pmul_b(a0) ^ pmul_d(a1) ^ pmul_9(a2) ^ pmul_e(a3)};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// ============================================================================
// aes_inv_round: one combinational inverse round; last skips InvMixColumns.
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_inv_round
    import aes_inv_pkg::*;
(
    input  block_t state_in,
    input  block_t rk,
    input  logic   last,
    output block_t state_out
);

    block_t w_shift;
    block_t w_sub;
    block_t w_ark;
    block_t w_mix;

    // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int c_row = i % 4;
        localparam int c_col = i / 4;
        localparam int c_src = c_row + 4 * ((c_col - c_row + 4) % 4);

        assign w_shift[127-8*i -: 8] = state_in[127-8*c_src -: 8];

        aes_inv_sbox u_sbox (
            .din  (w_shift[127-8*i -: 8]),
            .dout (w_sub[127-8*i -: 8])
        );
    end

    assign w_ark = w_sub ^ rk;

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_mix[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end

    assign state_out = last ? w_ark : w_mix;

endmodule

`default_nettype wire

// File: rtl/aes_inv_sbox.sv
// ============================================================================
// aes_inv_sbox: AES inverse S-box, inverse affine map followed by GF inverse.
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_inv_sbox
    import aes_inv_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    logic [7:0] w_aff;

    assign w_aff = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
    assign dout  = gf_inv(w_aff);

endmodule

`default_nettype wire

// File: rtl/aes_inv_cipher_nk.sv
// ============================================================================
// aes_inv_cipher_nk: iterative AES-128/192/256 inverse cipher, one round/clock,
// loaded round-key store. Define AES_INV_CBC_EN for CBC chaining. Rev 1.0
// ============================================================================
`default_nettype none

module aes_inv_cipher_nk
    import aes_inv_pkg::*;
#(
    parameter int KEY_BITS = 128,
    parameter int RK_AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rk_we,
    input  logic [RK_AW-1:0] rk_addr,
    input  logic [127:0]     rk_data,
    input  logic             key_clr,
    output logic             key_ready,
    output logic             rk_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     text_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     text_out
`ifdef AES_INV_CBC_EN
    ,
    input  logic             iv_we,
    input  logic [127:0]     iv
`endif
);

    localparam int c_nr = nr_of(KEY_BITS);

    if (c_nr == 0 || (1 << RK_AW) <= c_nr) begin : g_bad_cfg
        $error("aes_inv_cipher_nk: KEY_BITS must be 128/192/256 and RK_AW must index NR+1 keys");
    end

    state_t           r_state;
    state_t           w_state_nx;
    logic [RK_AW-1:0] r_rnd;
    block_t           r_blk;
    block_t           r_rk [0:c_nr];
    block_t           w_rk_sel;
    block_t           w_rnd_out;
    block_t           w_chain;
    block_t           r_text_out;
    logic [c_nr:0]    r_written;
    logic [c_nr:0]    w_written_nx;
    logic             r_key_ready;
    logic             r_rk_err;
    logic             r_out_valid;
    logic             w_idle;
    logic             w_last;
    logic             w_accept;
    logic             w_rk_ok;
    logic             w_rk_bad;

    assign w_idle   = (r_state == IDLE);
    assign w_last   = (r_state == FINAL);
    assign in_ready = w_idle && r_key_ready && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_rk_ok  = rk_we && w_idle && (rk_addr <= RK_AW'(c_nr));

    assign key_ready = r_key_ready;
    assign rk_err    = r_rk_err;
    assign out_valid = r_out_valid;
    assign text_out  = r_text_out;

    // Clear takes effect before a same-cycle write so the write survives.
    always_comb begin
        w_written_nx = key_clr ? '0 : r_written;
        for (int i = 0; i <= c_nr; i++) begin
            if (w_rk_ok && rk_addr == RK_AW'(i)) w_written_nx[i] = 1'b1;
        end
    end

    always_comb begin
        w_rk_sel = r_rk[0];
        for (int i = 1; i <= c_nr; i++) begin
            if (r_rnd == RK_AW'(i)) w_rk_sel = r_rk[i];
        end
    end

    // Key values are never erased; key_clr only drops the written mask.
    always_ff @(posedge clk) begin
        for (int i = 0; i <= c_nr; i++) begin
            if (w_rk_ok && rk_addr == RK_AW'(i)) r_rk[i] <= rk_data;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nx = ROUND;
            ROUND:   if (r_rnd == RK_AW'(1)) w_state_nx = FINAL;
            FINAL:   w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    aes_inv_round u_round (
        .state_in  (r_blk),
        .rk        (w_rk_sel),
        .last      (w_last),
        .state_out (w_rnd_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rnd       <= '0;
            r_blk       <= '0;
            r_written   <= '0;
            r_key_ready <= 1'b0;
            r_rk_err    <= 1'b0;
            r_out_valid <= 1'b0;
            r_text_out  <= '0;
        end else begin
            r_written   <= w_written_nx;
            r_key_ready <= &w_written_nx;
            r_rk_err    <= w_rk_bad;
            if (w_accept) begin
                r_blk <= text_in ^ r_rk[c_nr];
                r_rnd <= RK_AW'(c_nr - 1);
            end else if (r_state == ROUND) begin
                r_blk <= w_rnd_out;
                r_rnd <= r_rnd - RK_AW'(1);
            end
            if (w_last) begin
                r_out_valid <= 1'b1;
                r_text_out  <= w_rnd_out ^ w_chain;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef AES_INV_CBC_EN
    block_t r_chain;
    block_t r_cur_ct;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain  <= '0;
            r_cur_ct <= '0;
        end else begin
            if (iv_we && w_idle) r_chain <= iv;
            else if (w_last)     r_chain <= r_cur_ct;
            if (w_accept) r_cur_ct <= text_in;
        end
    end

    assign w_chain  = r_chain;
    assign w_rk_bad = (rk_we && !w_rk_ok) || (iv_we && !w_idle);
`else
    assign w_chain  = '0;
    assign w_rk_bad = rk_we && !w_rk_ok;
`endif

endmodule

`default_nettype wire
